// File: rtl/rst_req_pkg.sv
// Shared definitions for the reset request generator: FSM encoding,
// shared counter width and the request counter saturation value.
// Pure declarations, no logic.
package rst_req_pkg;

  localparam int CNT_W = 16;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_DEBOUNCE     = 3'd1,
    ST_ASSERT       = 3'd2,
    ST_HOLDOFF      = 3'd3,
    ST_WAIT_RELEASE = 3'd4
  } state_t;

  localparam logic [7:0] REQ_CNT_MAX = 8'hFF;

  // Terminal value of the shared counter for a phase lasting 'cycles' cycles
  function automatic cnt_t last_cnt(input int unsigned cycles);
    return cnt_t'(cycles - 1);
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer bringing the raw button into the clk domain.
// Latency: 2 cycles from first sampling edge to output.
// No backpressure; output simply follows the input two edges later.
module btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // Metastability filter: first flop may go metastable, second resolves it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/rst_request_gen.sv
// Turns a debounced button or a software request into a fixed-width reset pulse with lockout.
// Latency: sw_req -> rst_req 1 cycle; button -> rst_req DEBOUNCE_CYCLES+2 cycles after first sample.
// No backpressure: requests arriving during a pulse or the lockout window are dropped, not queued.
module rst_request_gen
  import rst_req_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned PULSE_CYCLES    = 4,
  parameter int unsigned HOLDOFF_CYCLES  = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  input  logic       sw_req,
  output logic       rst_req,
  output logic       busy,
  output logic [7:0] req_count
);

  // Zero-length or counter-overflowing phases cannot be represented
  generate
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
      $error("DEBOUNCE_CYCLES must be in 1..65535");
    end
    if (PULSE_CYCLES < 1 || PULSE_CYCLES > 65535) begin : g_bad_pulse
      $error("PULSE_CYCLES must be in 1..65535");
    end
    if (HOLDOFF_CYCLES < 1 || HOLDOFF_CYCLES > 65535) begin : g_bad_holdoff
      $error("HOLDOFF_CYCLES must be in 1..65535");
    end
  endgenerate

  localparam cnt_t LP_DEB_LAST   = last_cnt(DEBOUNCE_CYCLES);
  localparam cnt_t LP_PULSE_LAST = last_cnt(PULSE_CYCLES);
  localparam cnt_t LP_HOLD_LAST  = last_cnt(HOLDOFF_CYCLES);

  logic       w_btn_s;
  state_t     r_state;
  state_t     w_next_state;
  cnt_t       r_cnt;
  cnt_t       w_next_cnt;
  logic       r_rst_req;
  logic       r_busy;
  logic [7:0] r_req_count;
  logic       w_rst_req_nxt;
  logic       w_busy_nxt;
  logic [7:0] w_req_count_nxt;

  btn_sync u_btn_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (btn_in),
    .o_sync  (w_btn_s)
  );

  // State register and the single counter shared by every timed phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // Next-state and counter update; every phase entry restarts the counter at 0
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (sw_req) begin
          w_next_state = ST_ASSERT;
          w_next_cnt   = '0;
        end else if (w_btn_s) begin
          w_next_state = ST_DEBOUNCE;
          w_next_cnt   = '0;
        end
      end
      ST_DEBOUNCE: begin
        if (sw_req) begin
          w_next_state = ST_ASSERT;
          w_next_cnt   = '0;
        end else if (!w_btn_s) begin
          w_next_state = ST_IDLE;
          w_next_cnt   = '0;
        end else if (r_cnt == LP_DEB_LAST) begin
          w_next_state = ST_ASSERT;
          w_next_cnt   = '0;
        end else begin
          w_next_cnt = r_cnt + cnt_t'(1);
        end
      end
      ST_ASSERT: begin
        // Inputs are deliberately ignored so the pulse width is never cut short
        if (r_cnt == LP_PULSE_LAST) begin
          w_next_state = ST_HOLDOFF;
          w_next_cnt   = '0;
        end else begin
          w_next_cnt = r_cnt + cnt_t'(1);
        end
      end
      ST_HOLDOFF: begin
        // A still-held button must be released before it can trigger again
        if (r_cnt == LP_HOLD_LAST) begin
          w_next_state = w_btn_s ? ST_WAIT_RELEASE : ST_IDLE;
          w_next_cnt   = '0;
        end else begin
          w_next_cnt = r_cnt + cnt_t'(1);
        end
      end
      ST_WAIT_RELEASE: begin
        if (sw_req) begin
          w_next_state = ST_ASSERT;
          w_next_cnt   = '0;
        end else if (!w_btn_s) begin
          w_next_state = ST_IDLE;
          w_next_cnt   = '0;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_cnt   = '0;
      end
    endcase
  end

  // Output decode from the next state so registered outputs line up with the state flop
  always_comb begin
    w_rst_req_nxt   = (w_next_state == ST_ASSERT);
    w_busy_nxt      = (w_next_state != ST_IDLE);
    w_req_count_nxt = r_req_count;
    if (w_rst_req_nxt && (r_state != ST_ASSERT) && (r_req_count != REQ_CNT_MAX)) begin
      w_req_count_nxt = r_req_count + 8'd1;
    end
  end

  // Output flops: rst_req has no combinational path from any input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rst_req   <= 1'b0;
      r_busy      <= 1'b0;
      r_req_count <= '0;
    end else begin
      r_rst_req   <= w_rst_req_nxt;
      r_busy      <= w_busy_nxt;
      r_req_count <= w_req_count_nxt;
    end
  end

  assign rst_req   = r_rst_req;
  assign busy      = r_busy;
  assign req_count = r_req_count;

endmodule

// File: tb/tb_rst_request_gen.sv
// Directed bench for rst_request_gen at default parameters.
// Inputs driven 1 ns after the rising edge, outputs sampled at the same point.
// Expected values are hand-derived cycle indices relative to the first driving edge.
module tb_rst_request_gen;

  logic       clk;
  logic       rst;
  logic       btn_in;
  logic       sw_req;
  logic       rst_req;
  logic       busy;
  logic [7:0] req_count;

  int n_checks;
  int n_errors;

  rst_request_gen #(
    .DEBOUNCE_CYCLES (16),
    .PULSE_CYCLES    (4),
    .HOLDOFF_CYCLES  (64)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .sw_req    (sw_req),
    .rst_req   (rst_req),
    .busy      (busy),
    .req_count (req_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst    = 1'b1;
    btn_in = 1'b0;
    sw_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
  endtask

  int n_hi;
  int first_hi;
  int last_rise;
  int n_rise;
  int n_busy;
  int last_busy;
  logic prev_req;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    btn_in   = 1'b0;
    sw_req   = 1'b0;

    // Reset state
    #12;
    check_eq("rst_rst_req", 32'(rst_req), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_req_count", 32'(req_count), 32'd0);
    apply_reset();
    check_eq("idle_busy", 32'(busy), 32'd0);

    // Short button press: debounce aborted, no pulse
    n_hi = 0;
    for (int i = 1; i <= 10; i++) begin
      btn_in = 1'b1;
      tick();
      if (rst_req) n_hi++;
    end
    check_eq("short_busy_in_debounce", 32'(busy), 32'd1);
    btn_in = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (rst_req) n_hi++;
    end
    check_eq("short_no_pulse", 32'(n_hi), 32'd0);
    check_eq("short_busy_low", 32'(busy), 32'd0);
    check_eq("short_count", 32'(req_count), 32'd0);

    // Held button: rise 18 cycles after first sample (edge 1 -> high after edge 19), 4 wide, one pulse only
    n_hi = 0;
    first_hi = 0;
    for (int i = 1; i <= 100; i++) begin
      btn_in = 1'b1;
      tick();
      if (rst_req) begin
        n_hi++;
        if (first_hi == 0) first_hi = i;
      end
    end
    check_eq("btn_rise_idx", 32'(first_hi), 32'd19);
    check_eq("btn_width", 32'(n_hi), 32'd4);
    check_eq("btn_count", 32'(req_count), 32'd1);
    check_eq("btn_wait_release_busy", 32'(busy), 32'd1);
    btn_in = 1'b0;
    tick();
    tick();
    check_eq("release_sync_delay_busy", 32'(busy), 32'd1);
    tick();
    check_eq("release_busy_low", 32'(busy), 32'd0);

    // sw_req pulse: rst_req after 1 cycle, busy 68 cycles, request inside holdoff dropped
    n_hi = 0;
    first_hi = 0;
    n_busy = 0;
    last_busy = 0;
    for (int i = 1; i <= 80; i++) begin
      sw_req = (i == 1) || (i == 30);
      tick();
      if (rst_req) begin
        n_hi++;
        if (first_hi == 0) first_hi = i;
      end
      if (busy) begin
        n_busy++;
        last_busy = i;
      end
    end
    check_eq("sw_rise_idx", 32'(first_hi), 32'd1);
    check_eq("sw_width", 32'(n_hi), 32'd4);
    check_eq("sw_busy_cycles", 32'(n_busy), 32'd68);
    check_eq("sw_busy_last", 32'(last_busy), 32'd68);
    check_eq("sw_count", 32'(req_count), 32'd2);

    // Reset mid-pulse drops rst_req asynchronously, nothing pending afterwards
    sw_req = 1'b1;
    tick();
    sw_req = 1'b0;
    check_eq("midrst_assert_c1", 32'(rst_req), 32'd1);
    tick();
    check_eq("midrst_assert_c2", 32'(rst_req), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("midrst_req_async", 32'(rst_req), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_count", 32'(req_count), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_hi = 0;
    n_busy = 0;
    for (int i = 1; i <= 80; i++) begin
      tick();
      if (rst_req) n_hi++;
      if (busy) n_busy++;
    end
    check_eq("midrst_no_pulse", 32'(n_hi), 32'd0);
    check_eq("midrst_no_busy", 32'(n_busy), 32'd0);

    // Held button 200 cycles with sw_req in WAIT_RELEASE: second pulse at 150
    n_hi = 0;
    n_rise = 0;
    last_rise = 0;
    prev_req = 1'b0;
    for (int i = 1; i <= 230; i++) begin
      btn_in = (i <= 200);
      sw_req = (i == 150);
      tick();
      if (rst_req) n_hi++;
      if (rst_req && !prev_req) begin
        n_rise++;
        last_rise = i;
      end
      prev_req = rst_req;
    end
    check_eq("wr_rises", 32'(n_rise), 32'd2);
    check_eq("wr_second_rise_idx", 32'(last_rise), 32'd150);
    check_eq("wr_total_width", 32'(n_hi), 32'd8);
    check_eq("wr_count", 32'(req_count), 32'd2);
    check_eq("wr_busy_end", 32'(busy), 32'd0);

    // Saturation: 300 sw_req pulses spaced 80 cycles
    apply_reset();
    for (int p = 1; p <= 300; p++) begin
      sw_req = 1'b1;
      tick();
      sw_req = 1'b0;
      repeat (79) tick();
      if (p == 254) check_eq("sat_254", 32'(req_count), 32'd254);
      if (p == 255) check_eq("sat_255", 32'(req_count), 32'd255);
    end
    check_eq("sat_300", 32'(req_count), 32'd255);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
